// File: rtl/model_cpu.sv
// Top-level core of the model computer: 8-bit accumulator CPU, six GP registers, 256x8 edit-loaded ROM.
// Optional feature: define ALU_EXT_EN to turn ALU functions 110/111 into XOR/XNOR (otherwise they yield 0x00).
module model_cpu (
    input  logic       clk,
    input  logic       rst,
    input  logic       rstROM,
    input  logic       NEXT,
    input  logic       RUN,
    input  logic       SPEEDRUN,
    input  logic       edit,
    input  logic [7:0] unit,
    input  logic [7:0] code,
    input  logic       send,
    input  logic [7:0] I,
    output logic [7:0] O,
    output logic       IEnable,
    output logic       OEnable,
    output logic [7:0] reg0_monitor_signal,
    output logic [7:0] reg1_monitor_signal,
    output logic [7:0] reg2_monitor_signal,
    output logic [7:0] reg3_monitor_signal,
    output logic [7:0] reg4_monitor_signal,
    output logic [7:0] reg5_monitor_signal,
    output logic [7:0] counter_monitor_signal,
    output logic [7:0] O_monitor_signal
);

    localparam logic [1:0] OP_IMM  = 2'b00;
    localparam logic [1:0] OP_ALU  = 2'b01;
    localparam logic [1:0] OP_COPY = 2'b10;
    localparam logic [1:0] OP_COND = 2'b11;

    logic [7:0]      rom_q [256];
    logic [5:0][7:0] regs_q, regs_d;
    logic [7:0]      pc_q, pc_d;
    logic [7:0]      o_q, o_d;
    logic            speed_q, speed_d;
    logic            next_q;
    logic            speedrun_q;

    logic [7:0] inst;
    logic [1:0] opcode;
    logic [2:0] src, dst;
    logic       exec;
    logic [7:0] alu_res;
    logic [7:0] src_val;
    logic       cond_true;

    assign inst   = rom_q[pc_q];
    assign opcode = inst[7:6];
    assign src    = inst[5:3];
    assign dst    = inst[2:0];
    assign exec   = !rst && !edit && (RUN || speed_q || (NEXT && !next_q));

    // NOTE: the ROM is cleared only by rstROM, never by rst, so it has no reset branch of its own.
    always_ff @(posedge clk) begin
        if (rstROM) begin
            for (int i = 0; i < 256; i++) rom_q[i] <= 8'h00;
        end else if (edit && send) begin
            rom_q[unit] <= code;
        end
    end

    always_comb begin
        unique case (inst[2:0])
            3'b000:  alu_res = regs_q[1] | regs_q[2];
            3'b001:  alu_res = ~(regs_q[1] & regs_q[2]);
            3'b010:  alu_res = ~(regs_q[1] | regs_q[2]);
            3'b011:  alu_res = regs_q[1] & regs_q[2];
            3'b100:  alu_res = regs_q[1] + regs_q[2];
            3'b101:  alu_res = regs_q[1] - regs_q[2];
`ifdef ALU_EXT_EN
            3'b110:  alu_res = regs_q[1] ^ regs_q[2];
            default: alu_res = ~(regs_q[1] ^ regs_q[2]);
`else
            default: alu_res = 8'h00;
`endif
        endcase
    end

    // Source 6 is the input port, source 7 reads as zero.
    always_comb begin
        unique case (src)
            3'd6:    src_val = I;
            3'd7:    src_val = 8'h00;
            default: src_val = regs_q[src];
        endcase
    end

    always_comb begin
        unique case (inst[2:0])
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = (regs_q[3] == 8'h00);
            3'b010:  cond_true = regs_q[3][7];
            3'b011:  cond_true = regs_q[3][7] || (regs_q[3] == 8'h00);
            3'b100:  cond_true = 1'b1;
            3'b101:  cond_true = (regs_q[3] != 8'h00);
            3'b110:  cond_true = !regs_q[3][7];
            default: cond_true = !regs_q[3][7] && (regs_q[3] != 8'h00);
        endcase
    end

    // NOTE: every next-state signal gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        regs_d  = regs_q;
        pc_d    = pc_q;
        o_d     = o_q;
        speed_d = speed_q;
        if (exec) begin
            pc_d = (opcode == OP_COND && cond_true) ? regs_q[0] : pc_q + 8'd1;
            unique case (opcode)
                OP_IMM: regs_d[0] = {2'b00, inst[5:0]};
                OP_ALU: regs_d[3] = alu_res;
                OP_COPY: begin
                    if (dst == 3'd6)     o_d = src_val;
                    else if (dst != 3'd7) regs_d[dst] = src_val;
                end
                default: ;
            endcase
        end
        if (SPEEDRUN && !speedrun_q && !edit) speed_d = 1'b1;
        if (edit || (exec && pc_q == 8'hFF))  speed_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '0;
            pc_q       <= 8'h00;
            o_q        <= 8'h00;
            speed_q    <= 1'b0;
            next_q     <= 1'b0;
            speedrun_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pc_q       <= pc_d;
            o_q        <= o_d;
            speed_q    <= speed_d;
            next_q     <= NEXT;
            speedrun_q <= SPEEDRUN;
        end
    end

    assign IEnable                = exec && (opcode == OP_COPY) && (src == 3'd6);
    assign OEnable                = exec && (opcode == OP_COPY) && (dst == 3'd6);
    assign O                      = o_q;
    assign O_monitor_signal       = o_q;
    assign counter_monitor_signal = pc_q;
    assign reg0_monitor_signal    = regs_q[0];
    assign reg1_monitor_signal    = regs_q[1];
    assign reg2_monitor_signal    = regs_q[2];
    assign reg3_monitor_signal    = regs_q[3];
    assign reg4_monitor_signal    = regs_q[4];
    assign reg5_monitor_signal    = regs_q[5];

endmodule

// File: tb/tb_model_cpu.sv
// Self-checking bench for model_cpu: instruction vector table plus hand sequences, all through a scoreboard.
module tb_model_cpu;

    logic       clk = 1'b0;
    logic       rst = 1'b1, rstROM = 1'b0, NEXT = 1'b0, RUN = 1'b0, SPEEDRUN = 1'b0;
    logic       edit = 1'b0, send = 1'b0;
    logic [7:0] unit = 8'h00, code = 8'h00, I = 8'h00;
    logic [7:0] O, r0, r1, r2, r3, r4, r5, pc, om;
    logic       IEnable, OEnable;

    model_cpu dut (
        .clk(clk), .rst(rst), .rstROM(rstROM), .NEXT(NEXT), .RUN(RUN), .SPEEDRUN(SPEEDRUN),
        .edit(edit), .unit(unit), .code(code), .send(send), .I(I), .O(O),
        .IEnable(IEnable), .OEnable(OEnable),
        .reg0_monitor_signal(r0), .reg1_monitor_signal(r1), .reg2_monitor_signal(r2),
        .reg3_monitor_signal(r3), .reg4_monitor_signal(r4), .reg5_monitor_signal(r5),
        .counter_monitor_signal(pc), .O_monitor_signal(om)
    );

    always #5 clk = ~clk;

    typedef enum int {S_R0, S_R1, S_R2, S_R3, S_R4, S_R5, S_PC, S_O, S_OM, S_IEN, S_OEN} sel_e;
    typedef struct { string name; sel_e sel; logic [31:0] val; } exp_t;
    typedef struct {
        string name; logic [7:0] p0, p1, inst, i0, i1, exp_r3, exp_pc;
    } vec_t;

`ifdef ALU_EXT_EN
    localparam logic [7:0] EXP_XOR = 8'h96, EXP_XNOR = 8'h69;
`else
    localparam logic [7:0] EXP_XOR = 8'h00, EXP_XNOR = 8'h00;
`endif

    exp_t sb[$];
    vec_t vecs[$];
    int   tests = 0, fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] obs(input sel_e s);
        case (s)
            S_R0: return {24'h0, r0};
            S_R1: return {24'h0, r1};
            S_R2: return {24'h0, r2};
            S_R3: return {24'h0, r3};
            S_R4: return {24'h0, r4};
            S_R5: return {24'h0, r5};
            S_PC: return {24'h0, pc};
            S_O:  return {24'h0, O};
            S_OM: return {24'h0, om};
            S_IEN: return {31'h0, IEnable};
            default: return {31'h0, OEnable};
        endcase
    endfunction

    task automatic expect_val(input string name, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.name = name; e.sel = s; e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, obs(e.sel), e.val);
        end
    endtask

    task automatic tick(); @(negedge clk); endtask

    task automatic do_reset(); rst = 1'b1; tick(); rst = 1'b0; endtask

    task automatic write_rom(input logic [7:0] a, input logic [7:0] d);
        edit = 1'b1; unit = a; code = d; send = 1'b1;
        tick();
        send = 1'b0; edit = 1'b0;
    endtask

    task automatic step(); NEXT = 1'b1; tick(); NEXT = 1'b0; tick(); endtask

    task automatic add_vec(input string n, input logic [7:0] p0, p1, inst, i0, i1, r3e, pce);
        vec_t v;
        v.name = n; v.p0 = p0; v.p1 = p1; v.inst = inst;
        v.i0 = i0; v.i1 = i1; v.exp_r3 = r3e; v.exp_pc = pce;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        // ALU: r1 <- I, r2 <- I, then the ALU op; COND: r0 <- I (target), r3 <- I, then the branch.
        add_vec("alu_or",    8'hB1, 8'hB2, 8'h40, 8'hCA, 8'h5C, 8'hDE, 8'h03);
        add_vec("alu_nand",  8'hB1, 8'hB2, 8'h41, 8'hCA, 8'h5C, 8'hB7, 8'h03);
        add_vec("alu_nor",   8'hB1, 8'hB2, 8'h42, 8'hCA, 8'h5C, 8'h21, 8'h03);
        add_vec("alu_and",   8'hB1, 8'hB2, 8'h43, 8'hCA, 8'h5C, 8'h48, 8'h03);
        add_vec("alu_add",   8'hB1, 8'hB2, 8'h44, 8'hCA, 8'h5C, 8'h26, 8'h03);
        add_vec("alu_sub",   8'hB1, 8'hB2, 8'h45, 8'hCA, 8'h5C, 8'h6E, 8'h03);
        add_vec("alu_f6",    8'hB1, 8'hB2, 8'h46, 8'hCA, 8'h5C, EXP_XOR, 8'h03);
        add_vec("alu_f7",    8'hB1, 8'hB2, 8'h47, 8'hCA, 8'h5C, EXP_XNOR, 8'h03);
        add_vec("add_wrap",  8'hB1, 8'hB2, 8'h44, 8'hFF, 8'h01, 8'h00, 8'h03);
        add_vec("sub_wrap",  8'hB1, 8'hB2, 8'h45, 8'h10, 8'h20, 8'hF0, 8'h03);
        add_vec("c_never",   8'hB0, 8'hB3, 8'hC0, 8'h10, 8'h00, 8'h00, 8'h03);
        add_vec("c_eq_t",    8'hB0, 8'hB3, 8'hC1, 8'h10, 8'h00, 8'h00, 8'h10);
        add_vec("c_eq_f",    8'hB0, 8'hB3, 8'hC1, 8'h10, 8'h05, 8'h05, 8'h03);
        add_vec("c_lt_t",    8'hB0, 8'hB3, 8'hC2, 8'h10, 8'hFF, 8'hFF, 8'h10);
        add_vec("c_lt_f",    8'hB0, 8'hB3, 8'hC2, 8'h10, 8'h00, 8'h00, 8'h03);
        add_vec("c_le_t",    8'hB0, 8'hB3, 8'hC3, 8'h10, 8'h00, 8'h00, 8'h10);
        add_vec("c_le_f",    8'hB0, 8'hB3, 8'hC3, 8'h10, 8'h05, 8'h05, 8'h03);
        add_vec("c_always",  8'hB0, 8'hB3, 8'hC4, 8'h10, 8'h05, 8'h05, 8'h10);
        add_vec("c_ne_t",    8'hB0, 8'hB3, 8'hC5, 8'h10, 8'h80, 8'h80, 8'h10);
        add_vec("c_ne_f",    8'hB0, 8'hB3, 8'hC5, 8'h10, 8'h00, 8'h00, 8'h03);
        add_vec("c_ge_t",    8'hB0, 8'hB3, 8'hC6, 8'h10, 8'h00, 8'h00, 8'h10);
        add_vec("c_ge_f",    8'hB0, 8'hB3, 8'hC6, 8'h10, 8'h80, 8'h80, 8'h03);
        add_vec("c_gt_t",    8'hB0, 8'hB3, 8'hC7, 8'h10, 8'h05, 8'h05, 8'h10);
        add_vec("c_gt_f",    8'hB0, 8'hB3, 8'hC7, 8'h10, 8'h00, 8'h00, 8'h03);

        // Reset state, with ROM cleared alongside.
        rstROM = 1'b1; tick(); tick(); rstROM = 1'b0; rst = 1'b0;
        expect_val("rst_r0", S_R0, 0); expect_val("rst_r3", S_R3, 0); expect_val("rst_r5", S_R5, 0);
        expect_val("rst_pc", S_PC, 0); expect_val("rst_o", S_O, 0);
        expect_val("rst_ien", S_IEN, 0); expect_val("rst_oen", S_OEN, 0);
        drain();

        // RUN through IMM 0x00, 0x10, 0x30, then one more zero byte.
        write_rom(8'd1, 8'h10); write_rom(8'd2, 8'h30);
        RUN = 1'b1; tick(); tick(); tick(); RUN = 1'b0;
        expect_val("run3_r0", S_R0, 8'h30); expect_val("run3_pc", S_PC, 3); drain();
        RUN = 1'b1; tick(); RUN = 1'b0;
        expect_val("run4_r0", S_R0, 8'h00); expect_val("run4_pc", S_PC, 4); drain();

        // NEXT stepping: held NEXT executes exactly once.
        do_reset();
        write_rom(8'd0, 8'h05); write_rom(8'd1, 8'h81); write_rom(8'd2, 8'h03);
        write_rom(8'd3, 8'h82); write_rom(8'd4, 8'h44);
        NEXT = 1'b1; tick(); tick(); tick(); NEXT = 1'b0; tick();
        expect_val("next_hold_pc", S_PC, 1); expect_val("next_hold_r0", S_R0, 8'h05); drain();
        step(); step(); step(); step();
        expect_val("step_r1", S_R1, 8'h05); expect_val("step_r2", S_R2, 8'h03);
        expect_val("step_r3", S_R3, 8'h08); expect_val("step_pc", S_PC, 5); drain();

        // Output and input ports with their enables.
        do_reset();
        write_rom(8'd0, 8'h2A); write_rom(8'd1, 8'h86); write_rom(8'd2, 8'hB0);
        I = 8'h77;
        step();
        NEXT = 1'b1; #1;
        expect_val("oen_pulse", S_OEN, 1); expect_val("ien_quiet", S_IEN, 0); drain();
        tick(); NEXT = 1'b0; tick();
        expect_val("o_val", S_O, 8'h2A); expect_val("o_mon", S_OM, 8'h2A);
        expect_val("oen_off", S_OEN, 0); drain();
        NEXT = 1'b1; #1;
        expect_val("ien_pulse", S_IEN, 1); expect_val("oen_quiet", S_OEN, 0); drain();
        tick(); NEXT = 1'b0; tick();
        expect_val("i_to_r0", S_R0, 8'h77); expect_val("o_hold", S_O, 8'h2A); drain();

        // Instruction vector table.
        foreach (vecs[k]) begin
            do_reset();
            write_rom(8'd0, vecs[k].p0); write_rom(8'd1, vecs[k].p1); write_rom(8'd2, vecs[k].inst);
            I = vecs[k].i0; step();
            I = vecs[k].i1; step();
            expect_val({vecs[k].name, "_r3"}, S_R3, {24'h0, vecs[k].exp_r3});
            expect_val({vecs[k].name, "_pc"}, S_PC, {24'h0, vecs[k].exp_pc});
            step();
            drain();
        end

        // rst while RUN is high clears state but keeps ROM.
        do_reset();
        write_rom(8'd0, 8'h15); write_rom(8'd1, 8'h86); write_rom(8'd2, 8'h81);
        RUN = 1'b1; tick(); tick(); tick();
        expect_val("pre_rst_r1", S_R1, 8'h15); expect_val("pre_rst_o", S_O, 8'h15); drain();
        rst = 1'b1; tick(); rst = 1'b0; RUN = 1'b0;
        expect_val("mid_rst_r0", S_R0, 0); expect_val("mid_rst_r1", S_R1, 0);
        expect_val("mid_rst_pc", S_PC, 0); expect_val("mid_rst_o", S_O, 0); drain();
        step();
        expect_val("rom_kept_r0", S_R0, 8'h15); expect_val("rom_kept_pc", S_PC, 1); drain();

        // rstROM beats a coincident edit write.
        do_reset();
        edit = 1'b1; send = 1'b1; unit = 8'd0; code = 8'h25; rstROM = 1'b1;
        tick();
        edit = 1'b0; send = 1'b0; rstROM = 1'b0;
        step();
        expect_val("romclr_wins_r0", S_R0, 0); expect_val("romclr_wins_pc", S_PC, 1); drain();

        // SPEEDRUN pulse, frozen and cancelled by edit.
        do_reset();
        SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
        repeat (100) tick();
        expect_val("speed_pc100", S_PC, 100); drain();
        edit = 1'b1; repeat (4) tick();
        expect_val("edit_freeze_pc", S_PC, 100); drain();
        edit = 1'b0; repeat (4) tick();
        expect_val("edit_cancel_pc", S_PC, 100); drain();

        // SPEEDRUN full lap: 256 executions, then stop at PC 0.
        do_reset();
        SPEEDRUN = 1'b1; tick(); SPEEDRUN = 1'b0;
        n = 0;
        do begin tick(); n++; end while (pc != 8'h00 && n < 300);
        check("speed_lap_cycles", n, 256);
        repeat (8) tick();
        expect_val("speed_stopped_pc", S_PC, 0); drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
